wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The module SHALL take these parameters, one per line: name, default, meaning.
- DATA_W, 32, datapath width.
- ADDR_W, 5, register-file address width.
- LINK_OFFSET, 8, link-value offset added to pc.

REQ-002 The module SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on its rising edge.
- reset, in, 1, reset, synchronous, active-high.
- in_valid, in, 1, MEM-side entry offered.
- in_ready, out, 1, stage can accept this cycle.
- in_pc, in, DATA_W, pc of the entry.
- in_instr, in, 32, instruction word.
- in_wr_en, in, 1, entry writes the register file.
- in_wr_addr, in, ADDR_W, destination register, already resolved.
- in_sel, in, 2, result source: 0 = alu, 1 = mem, 2 = link.
- in_ld_mode, in, 3, load mode: 0 = lw, 1 = lb, 2 = lbu, 3 = lh, 4 = lhu.
- in_byte_off, in, 2, load address bits [1:0].
- in_alu, in, DATA_W, ALU result.
- in_mem, in, DATA_W, raw memory read word.
- flush, in, 1, discard the stage entry.
- md_valid, in, 1, multiply/divide unit result offered.
- md_ready, out, 1, md result accepted.
- md_addr, in, ADDR_W, md destination register.
- md_data, in, DATA_W, md result.
- rf_we, out, 1, register-file write enable.
- rf_waddr, out, ADDR_W, register-file write address.
- rf_wdata, out, DATA_W, register-file write data.
- wb_pc, out, DATA_W, pc of the entry in the stage (trace output).
- wb_instr, out, 32, instruction word of the entry in the stage (trace output).
- fwd_valid, out, 1, forwarding source valid.
- fwd_addr, out, ADDR_W, forwarding register.
- fwd_data, out, DATA_W, forwarding data.
- retired_cnt, out, 32, count of register-file writes performed.

Function
REQ-003 The stage register S SHALL capture the entry on in_valid & in_ready, and the write data SHALL be resolved at capture time:
- alu when in_sel = 0;
- load-extended in_mem when in_sel = 1;
- in_pc + LINK_OFFSET when in_sel = 2 (modulo 2^DATA_W).
REQ-004 Load extraction SHALL select lanes as follows:
- byte lane = in_mem[8*off +: 8];
- half lane = in_mem[16*off[1] +: 16];
- lb/lh sign-extend; lbu/lhu zero-extend; lw ignores off.
REQ-005 The one register-file port SHALL be granted each cycle in this priority: md buffer B, then S, then a direct md_valid.
REQ-006 An entry SHALL retire when it holds the grant; rf_we/rf_waddr/rf_wdata SHALL then be driven combinationally from the granted source in the same cycle.
REQ-007 An S entry with wr_en = 0, or with wr_addr = 0, SHALL retire in the cycle after capture without using the port; rf_we SHALL stay 0 for it.
REQ-008 in_ready SHALL equal !S.valid | S retires this cycle; minimum latency is 1 cycle from acceptance to rf_we.
REQ-009 B SHALL be a 1-entry buffer, with md_ready = !B.valid.
- An accepted md result not granted directly SHALL load B.
- B SHALL drain on its next grant.
- md_addr = 0 SHALL be accepted and dropped.
REQ-010 fwd_* SHALL mirror the S entry whenever S.valid & wr_en & wr_addr != 0; otherwise fwd_valid = 0.
REQ-011 flush SHALL clear S.valid at the clock edge; flush with in_valid in the same cycle drops the input (flush wins). flush SHALL NOT affect B.
REQ-012 retired_cnt SHALL increment on every rf_we = 1 cycle and wrap 0xFFFFFFFF -> 0.
REQ-013 Write-after-write ordering between md results and pipeline entries SHALL be guaranteed by the hazard unit upstream; this block SHALL NOT check it.

Reset
REQ-014 reset SHALL clear on the next rising edge, overriding every other input:
- S.valid = 0, B.valid = 0, retired_cnt = 0;
- rf_we = 0, fwd_valid = 0;
- in_ready = 1, md_ready = 1;
- rf_waddr, rf_wdata, wb_pc, wb_instr = 0.
REQ-015 Reset mid-operation SHALL discard S and B contents without any write.

Structure
REQ-016 A shared package wb_pkg SHALL hold the in_sel and in_ld_mode encodings and the LINK_OFFSET default.
REQ-017 Load extraction SHALL be a combinational sub-module, load_ext (DATA_W-parametrised).

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- lb, in_mem = 0x12345680, off = 0, addr 4 -> next cycle rf_we = 1, rf_waddr = 4, rf_wdata = 0xFFFFFF80; lbu -> 0x00000080.
- lh, off = 2, in_mem = 0x8001_7FFF -> 0xFFFF8001; link, pc = 0x00003000, addr 31 -> rf_wdata = 0x00003008.
- md_valid with S writing addr 5 in the same cycle -> md goes to B, md_ready falls; next cycle B writes; the S entry after it stalls (in_ready = 0) for one cycle.
- addr 0 with wr_en = 1 -> rf_we never asserts; retired_cnt unchanged; in_ready stays 1.
- flush with in_valid in the same cycle -> no write, fwd_valid = 0; a B entry pending at the same time still writes.
- reset asserted while B is full -> next cycle B.valid = 0, md_ready = 1, retired_cnt = 0; preload retired_cnt at 0xFFFFFFFF and write once -> 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared encodings for the write-back stage: result-source select, load modes
// and the default link offset.
package wb_pkg;

    typedef enum logic [1:0] {
        SEL_ALU  = 2'd0,
        SEL_MEM  = 2'd1,
        SEL_LINK = 2'd2
    } sel_e;

    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_B  = 3'd1,
        LD_BU = 3'd2,
        LD_H  = 3'd3,
        LD_HU = 3'd4
    } ld_mode_e;

    localparam int LINK_OFFSET_DEF = 8;

endpackage

// File: rtl/load_ext.sv
// Combinational load extraction: picks the byte/half lane addressed by the low
// address bits and sign- or zero-extends it to the datapath width.
module load_ext
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] mem,
    input  logic [2:0]        mode,
    input  logic [1:0]        off,
    output logic [DATA_W-1:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = mem[{off, 3'b000} +: 8];
    assign lane_h = mem[{off[1], 4'b0000} +: 16];

    // Unused mode encodings fall back to a full-word load.
    always_comb begin
        data = mem;
        case (mode)
            LD_B:    data = {{(DATA_W-8){lane_b[7]}}, lane_b};
            LD_BU:   data = {{(DATA_W-8){1'b0}}, lane_b};
            LD_H:    data = {{(DATA_W-16){lane_h[15]}}, lane_h};
            LD_HU:   data = {{(DATA_W-16){1'b0}}, lane_h};
            default: data = mem;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: one pipeline entry register S plus a one-deep buffer B for
// multiply/divide results, sharing a single register-file write port.
module wb_stage
    import wb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int LINK_OFFSET = LINK_OFFSET_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [31:0]       in_instr,
    input  logic              in_wr_en,
    input  logic [ADDR_W-1:0] in_wr_addr,
    input  logic [1:0]        in_sel,
    input  logic [2:0]        in_ld_mode,
    input  logic [1:0]        in_byte_off,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_mem,
    input  logic              flush,
    input  logic              md_valid,
    output logic              md_ready,
    input  logic [ADDR_W-1:0] md_addr,
    input  logic [DATA_W-1:0] md_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [DATA_W-1:0] wb_pc,
    output logic [31:0]       wb_instr,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    output logic [31:0]       retired_cnt
);

    logic              s_valid;
    logic              s_wr_en;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_data;
    logic [DATA_W-1:0] s_pc;
    logic [31:0]       s_instr;

    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;

    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] cap_data;
    logic              s_writes;
    logic              s_retire;
    logic              in_acc;
    logic              md_acc;
    logic              md_live;
    logic              grant_b;
    logic              grant_s;
    logic              grant_md;

    load_ext #(.DATA_W(DATA_W)) u_load_ext (
        .mem  (in_mem),
        .mode (in_ld_mode),
        .off  (in_byte_off),
        .data (ld_data)
    );

    always_comb begin
        cap_data = in_alu;
        case (in_sel)
            SEL_MEM:  cap_data = ld_data;
            SEL_LINK: cap_data = in_pc + DATA_W'(LINK_OFFSET);
            default:  cap_data = in_alu;
        endcase
    end

    assign s_writes = s_wr_en & (s_addr != '0);
    assign md_live  = md_valid & (md_addr != '0);

    // Port priority: buffered md result, then S, then a direct md result.
    assign grant_b  = b_valid;
    assign grant_s  = !b_valid & s_valid & s_writes;
    assign grant_md = !b_valid & !(s_valid & s_writes) & md_live;

    // Non-writing entries never need the port, so they leave unconditionally.
    assign s_retire = s_valid & (!s_writes | grant_s);
    assign in_ready = !s_valid | s_retire;
    assign md_ready = !b_valid;
    assign in_acc   = in_valid & in_ready & !flush;
    assign md_acc   = md_valid & md_ready;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (!reset) begin
            if (grant_b) begin
                rf_we    = 1'b1;
                rf_waddr = b_addr;
                rf_wdata = b_data;
            end else if (grant_s) begin
                rf_we    = 1'b1;
                rf_waddr = s_addr;
                rf_wdata = s_data;
            end else if (grant_md) begin
                rf_we    = 1'b1;
                rf_waddr = md_addr;
                rf_wdata = md_data;
            end
        end
    end

    assign wb_pc     = s_pc;
    assign wb_instr  = s_instr;
    assign fwd_valid = s_valid & s_writes;
    assign fwd_addr  = s_addr;
    assign fwd_data  = s_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            s_valid     <= 1'b0;
            s_wr_en     <= 1'b0;
            s_addr      <= '0;
            s_data      <= '0;
            s_pc        <= '0;
            s_instr     <= '0;
            b_valid     <= 1'b0;
            b_addr      <= '0;
            b_data      <= '0;
            retired_cnt <= '0;
        end else begin
            if (flush)
                s_valid <= 1'b0;
            else if (in_acc)
                s_valid <= 1'b1;
            else if (s_retire)
                s_valid <= 1'b0;

            if (in_acc) begin
                s_wr_en <= in_wr_en;
                s_addr  <= in_wr_addr;
                s_data  <= cap_data;
                s_pc    <= in_pc;
                s_instr <= in_instr;
            end

            // md results to register 0 are accepted but never stored.
            if (grant_b)
                b_valid <= 1'b0;
            else if (md_acc & md_live & !grant_md) begin
                b_valid <= 1'b1;
                b_addr  <= md_addr;
                b_data  <= md_data;
            end

            if (rf_we)
                retired_cnt <= retired_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus a short random load burst, with
// expected register-file writes queued at drive time and popped on rf_we.
module tb_wb_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_wr_en;
    logic [4:0]  in_wr_addr;
    logic [1:0]  in_sel;
    logic [2:0]  in_ld_mode;
    logic [1:0]  in_byte_off;
    logic [31:0] in_alu;
    logic [31:0] in_mem;
    logic        flush;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] wb_pc;
    logic [31:0] wb_instr;
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
    logic [31:0] retired_cnt;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } sb_t;

    sb_t sb[$];
    int  n_chk = 0;
    int  n_err = 0;
    int  n_wr  = 0;

    wb_stage dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_instr    (in_instr),
        .in_wr_en    (in_wr_en),
        .in_wr_addr  (in_wr_addr),
        .in_sel      (in_sel),
        .in_ld_mode  (in_ld_mode),
        .in_byte_off (in_byte_off),
        .in_alu      (in_alu),
        .in_mem      (in_mem),
        .flush       (flush),
        .md_valid    (md_valid),
        .md_ready    (md_ready),
        .md_addr     (md_addr),
        .md_data     (md_data),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .wb_pc       (wb_pc),
        .wb_instr    (wb_instr),
        .fwd_valid   (fwd_valid),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .retired_cnt (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_load(input logic [2:0] mode, input logic [1:0] off,
                                             input logic [31:0] mem);
        logic [31:0] sb8;
        logic [31:0] sh16;
        sb8  = mem >> (off * 8);
        sh16 = off[1] ? (mem >> 16) : mem;
        case (mode)
            3'd1:    return {{24{sb8[7]}}, sb8[7:0]};
            3'd2:    return {24'h0, sb8[7:0]};
            3'd3:    return {{16{sh16[15]}}, sh16[15:0]};
            3'd4:    return {16'h0, sh16[15:0]};
            default: return mem;
        endcase
    endfunction

    // Scoreboard consumer: every write the DUT makes must be the oldest expected one.
    always @(negedge clk) begin
        if (rf_we) begin
            n_wr++;
            if (sb.size() == 0) begin
                chk("unexpected_write_addr", 32'(rf_waddr), 32'hFFFF_FFFF);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("sb_waddr", 32'(rf_waddr), 32'(e.a));
                chk("sb_wdata", rf_wdata, e.d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [31:0] pc, input logic we, input logic [4:0] a,
                          input logic [1:0] sel, input logic [2:0] mode, input logic [1:0] off,
                          input logic [31:0] alu, input logic [31:0] mem);
        in_pc       = pc;
        in_instr    = {pc[15:0], 16'h0033};
        in_wr_en    = we;
        in_wr_addr  = a;
        in_sel      = sel;
        in_ld_mode  = mode;
        in_byte_off = off;
        in_alu      = alu;
        in_mem      = mem;
    endtask

    task automatic send(input logic [31:0] pc, input logic we, input logic [4:0] a,
                        input logic [1:0] sel, input logic [2:0] mode, input logic [1:0] off,
                        input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] exp_d);
        int n;
        set_in(pc, we, a, sel, mode, off, alu, mem);
        in_valid = 1'b1;
        if (we && a != 5'd0) sb.push_back('{a, exp_d});
        n = 0;
        while (!in_ready && n < 10) begin
            tick();
            n++;
        end
        if (n == 10) chk("accept_timeout", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int base;
        logic [1:0]  r_off;
        logic [2:0]  r_mode;
        logic [4:0]  r_addr;
        logic [31:0] r_mem;

        reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
        md_valid = 1'b0; md_addr = '0; md_data = '0;
        set_in(32'h0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 32'h0, 32'h0);
        tick(); tick();
        reset = 1'b0;
        chk("rst_in_ready",  32'(in_ready), 32'd1);
        chk("rst_md_ready",  32'(md_ready), 32'd1);
        chk("rst_rf_we",     32'(rf_we), 32'd0);
        chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
        chk("rst_cnt",       retired_cnt, 32'd0);
        chk("rst_waddr",     32'(rf_waddr), 32'd0);
        chk("rst_wdata",     rf_wdata, 32'd0);
        chk("rst_wb_pc",     wb_pc, 32'd0);
        chk("rst_wb_instr",  wb_instr, 32'd0);

        // Loads and link values, one cycle from acceptance to write.
        send(32'h40, 1'b1, 5'd4, 2'd1, 3'd1, 2'd0, 32'h0, 32'h1234_5680, 32'hFFFF_FF80);
        chk("lb_rf_we",    32'(rf_we), 32'd1);
        chk("lb_waddr",    32'(rf_waddr), 32'd4);
        chk("lb_wb_pc",    wb_pc, 32'h40);
        chk("lb_fwd_v",    32'(fwd_valid), 32'd1);
        chk("lb_fwd_data", fwd_data, 32'hFFFF_FF80);
        send(32'h44, 1'b1, 5'd4, 2'd1, 3'd2, 2'd0, 32'h0, 32'h1234_5680, 32'h0000_0080);
        send(32'h48, 1'b1, 5'd7, 2'd1, 3'd3, 2'd2, 32'h0, 32'h8001_7FFF, 32'hFFFF_8001);
        send(32'h4C, 1'b1, 5'd8, 2'd1, 3'd4, 2'd2, 32'h0, 32'h8001_7FFF, 32'h0000_8001);
        send(32'h3000, 1'b1, 5'd31, 2'd2, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0000_3008);
        chk("link_wdata", rf_wdata, 32'h0000_3008);
        send(32'h50, 1'b1, 5'd9, 2'd1, 3'd0, 2'd3, 32'h0, 32'hCAFE_BABE, 32'hCAFE_BABE);
        send(32'h54, 1'b1, 5'd10, 2'd0, 3'd1, 2'd1, 32'h1357_9BDF, 32'hFFFF_FFFF, 32'h1357_9BDF);
        tick();
        chk("cnt_after_loads", retired_cnt, 32'(n_wr));

        // md collides with a writing S entry: md buffers, next entry stalls one cycle.
        send(32'h100, 1'b1, 5'd5, 2'd0, 3'd0, 2'd0, 32'h55, 32'h0, 32'h55);
        chk("s3_md_ready_pre", 32'(md_ready), 32'd1);
        chk("s3_in_ready_pre", 32'(in_ready), 32'd1);
        md_valid = 1'b1; md_addr = 5'd9; md_data = 32'h0000_AAAA;
        sb.push_back('{5'd9, 32'h0000_AAAA});
        set_in(32'h104, 1'b1, 5'd6, 2'd0, 3'd0, 2'd0, 32'h66, 32'h0);
        in_valid = 1'b1;
        sb.push_back('{5'd6, 32'h66});
        tick();
        md_valid = 1'b0; in_valid = 1'b0;
        chk("s3_md_ready_low", 32'(md_ready), 32'd0);
        chk("s3_in_stall",     32'(in_ready), 32'd0);
        chk("s3_b_we",         32'(rf_we), 32'd1);
        chk("s3_b_waddr",      32'(rf_waddr), 32'd9);
        tick();
        chk("s3_in_ready_back", 32'(in_ready), 32'd1);
        chk("s3_md_ready_back", 32'(md_ready), 32'd1);
        chk("s3_s_waddr",       32'(rf_waddr), 32'd6);
        tick();
        chk("s3_idle_we", 32'(rf_we), 32'd0);

        // Direct md write and an md result to register 0.
        md_valid = 1'b1; md_addr = 5'd20; md_data = 32'hDEAD_0001;
        sb.push_back('{5'd20, 32'hDEAD_0001});
        #1;
        chk("md_direct_we", 32'(rf_we), 32'd1);
        tick();
        chk("md_direct_no_buf", 32'(md_ready), 32'd1);
        md_addr = 5'd0; md_data = 32'h1111_2222;
        #1;
        chk("md_zero_we", 32'(rf_we), 32'd0);
        tick();
        md_valid = 1'b0;
        chk("md_zero_dropped", 32'(md_ready), 32'd1);

        // Non-writing entries retire silently.
        c0 = retired_cnt;
        send(32'h200, 1'b1, 5'd0, 2'd0, 3'd0, 2'd0, 32'h77, 32'h0, 32'h0);
        chk("a0_rf_we",     32'(rf_we), 32'd0);
        chk("a0_in_ready",  32'(in_ready), 32'd1);
        chk("a0_fwd_valid", 32'(fwd_valid), 32'd0);
        send(32'h204, 1'b0, 5'd3, 2'd0, 3'd0, 2'd0, 32'h78, 32'h0, 32'h0);
        chk("we0_rf_we", 32'(rf_we), 32'd0);
        tick();
        chk("a0_cnt_same", retired_cnt, 32'(c0));

        // Flush drops a simultaneous input while a buffered md result still writes.
        send(32'h300, 1'b1, 5'd10, 2'd0, 3'd0, 2'd0, 32'hA0, 32'h0, 32'hA0);
        md_valid = 1'b1; md_addr = 5'd11; md_data = 32'hB0B0_0011;
        sb.push_back('{5'd11, 32'hB0B0_0011});
        tick();
        md_valid = 1'b0;
        chk("fl_b_full", 32'(md_ready), 32'd0);
        set_in(32'h304, 1'b1, 5'd12, 2'd0, 3'd0, 2'd0, 32'hC0, 32'h0);
        in_valid = 1'b1; flush = 1'b1;
        #1;
        chk("fl_b_we",    32'(rf_we), 32'd1);
        chk("fl_b_waddr", 32'(rf_waddr), 32'd11);
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("fl_no_write", 32'(rf_we), 32'd0);
        chk("fl_fwd",      32'(fwd_valid), 32'd0);
        chk("fl_in_ready", 32'(in_ready), 32'd1);
        chk("fl_md_ready", 32'(md_ready), 32'd1);
        tick();
        chk("cnt_before_rst", retired_cnt, 32'(n_wr));

        // Reset with B full discards it without a write.
        send(32'h400, 1'b1, 5'd13, 2'd0, 3'd0, 2'd0, 32'hD0, 32'h0, 32'hD0);
        md_valid = 1'b1; md_addr = 5'd14; md_data = 32'hEEEE_0014;
        tick();
        md_valid = 1'b0;
        chk("rs_b_full", 32'(md_ready), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rs_md_ready", 32'(md_ready), 32'd1);
        chk("rs_in_ready", 32'(in_ready), 32'd1);
        chk("rs_cnt",      retired_cnt, 32'd0);
        chk("rs_rf_we",    32'(rf_we), 32'd0);
        chk("rs_wb_pc",    wb_pc, 32'd0);
        tick();
        chk("rs_no_bwrite", 32'(rf_we), 32'd0);

        // Counter wrap.
        force dut.retired_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.retired_cnt;
        chk("wrap_preload", retired_cnt, 32'hFFFF_FFFF);
        send(32'h500, 1'b1, 5'd15, 2'd0, 3'd0, 2'd0, 32'hF15, 32'h0, 32'hF15);
        tick();
        chk("wrap_zero", retired_cnt, 32'd0);

        // Random back-to-back loads.
        base = n_wr;
        for (int i = 0; i < 16; i++) begin
            r_mode = 3'($urandom_range(0, 4));
            r_off  = 2'($urandom_range(0, 3));
            r_addr = 5'($urandom_range(1, 31));
            r_mem  = $urandom;
            send(32'h600 + 32'(i * 4), 1'b1, r_addr, 2'd1, r_mode, r_off, 32'h0, r_mem,
                 exp_load(r_mode, r_off, r_mem));
        end

        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        tick();
        chk("rand_cnt", retired_cnt, 32'(n_wr - base));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
